// File: rtl/sprite_mover.sv
// sprite_mover: tile-aligned sprite movement with a handshaked wall-map
// query before every step. Keys load a pending direction; on each frame
// tick the sprite either tries to turn, tries to continue ahead, or idles.
`timescale 1ns/1ps
module sprite_mover #(
  parameter int W         = 10,
  parameter int X_CENTER  = 320,
  parameter int Y_CENTER  = 240,
  parameter int X_MIN     = 26,
  parameter int X_MAX     = 598,
  parameter int Y_MIN     = 26,
  parameter int Y_MAX     = 454,
  parameter int SIZE      = 4,
  parameter int STEP      = 1,
  parameter int TILE_LOG2 = 3
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         frame_tick,
  input  logic [7:0]   keycode,
  output logic         wall_req,
  output logic [W-1:0] wall_x,
  output logic [W-1:0] wall_y,
  input  logic         wall_ack,
  input  logic         wall_hit,
  output logic [W-1:0] BallX,
  output logic [W-1:0] BallY,
  output logic [W-1:0] BallS,
  output logic [1:0]   dir,
  output logic         moving,
  output logic         overrun
);

  typedef enum logic [1:0] {IDLE, TURN_Q, AHEAD_Q, MOVE} state_t;

  localparam logic [1:0] DIR_R = 2'd0;
  localparam logic [1:0] DIR_L = 2'd1;
  localparam logic [1:0] DIR_D = 2'd2;
  localparam logic [1:0] DIR_U = 2'd3;

  localparam logic [W:0]          STEP_U = (W+1)'(STEP);
  localparam logic signed [W+1:0] STEP_S = (W+2)'(STEP);
  // Legal centre range: the sprite edge may not touch the playfield bound.
  localparam logic signed [W+1:0] XLO = (W+2)'(X_MIN + SIZE);
  localparam logic signed [W+1:0] XHI = (W+2)'(X_MAX - SIZE);
  localparam logic signed [W+1:0] YLO = (W+2)'(Y_MIN + SIZE);
  localparam logic signed [W+1:0] YHI = (W+2)'(Y_MAX - SIZE);

  state_t         state_q, state_d;
  logic [W-1:0]   x_q, x_d, y_q, y_d;
  logic [W-1:0]   wx_q, wx_d, wy_q, wy_d;
  logic [1:0]     dir_q, dir_d, pdir_q, pdir_d, qdir_q, qdir_d;
  logic           moving_q, moving_d, pend_q, pend_d;
  logic           req_q, req_d, over_q, over_d;

  logic [2:0]          key;
  logic                aligned, eligible;
  logic signed [W+1:0] xs, ys;
  logic [W:0]          cx, cy;

  // Key decode: {valid, direction}.
  function automatic logic [2:0] decode_key(input logic [7:0] kc);
    case (kc)
      8'h07:   return {1'b1, DIR_R};
      8'h04:   return {1'b1, DIR_L};
      8'h16:   return {1'b1, DIR_D};
      8'h1A:   return {1'b1, DIR_U};
      default: return 3'b000;
    endcase
  endfunction

  // Candidate coordinate one STEP along d (query address, no clamping).
  function automatic logic [W-1:0] step_x(input logic [W-1:0] x, input logic [1:0] d);
    logic [W:0] t;
    t = {1'b0, x};
    if (d == DIR_R)      t = t + STEP_U;
    else if (d == DIR_L) t = t - STEP_U;
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] step_y(input logic [W-1:0] y, input logic [1:0] d);
    logic [W:0] t;
    t = {1'b0, y};
    if (d == DIR_D)      t = t + STEP_U;
    else if (d == DIR_U) t = t - STEP_U;
    return t[W-1:0];
  endfunction

  // Saturate a widened coordinate into [lo, hi]; MSB of result flags a clamp.
  function automatic logic [W:0] clamp_axis(input logic signed [W+1:0] v,
                                            input logic signed [W+1:0] lo,
                                            input logic signed [W+1:0] hi);
    if (v <= lo)      return {1'b1, lo[W-1:0]};
    else if (v >= hi) return {1'b1, hi[W-1:0]};
    else              return {1'b0, v[W-1:0]};
  endfunction

  // State and datapath registers, all forced to the centred rest state by reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      x_q      <= W'(X_CENTER);
      y_q      <= W'(Y_CENTER);
      wx_q     <= W'(X_CENTER);
      wy_q     <= W'(Y_CENTER);
      dir_q    <= DIR_R;
      pdir_q   <= DIR_R;
      qdir_q   <= DIR_R;
      moving_q <= 1'b0;
      pend_q   <= 1'b0;
      req_q    <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      wx_q     <= wx_d;
      wy_q     <= wy_d;
      dir_q    <= dir_d;
      pdir_q   <= pdir_d;
      qdir_q   <= qdir_d;
      moving_q <= moving_d;
      pend_q   <= pend_d;
      req_q    <= req_d;
      over_q   <= over_d;
    end
  end

  // Key capture, then FSM next state; a granted turn's pend clear wins over a same-cycle key.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    wx_d     = wx_q;
    wy_d     = wy_q;
    dir_d    = dir_q;
    pdir_d   = pdir_q;
    qdir_d   = qdir_q;
    moving_d = moving_q;
    pend_d   = pend_q;
    req_d    = req_q;
    over_d   = over_q;
    xs       = signed'({2'b00, x_q});
    ys       = signed'({2'b00, y_q});
    cx       = '0;
    cy       = '0;

    key      = decode_key(keycode);
    aligned  = (x_q[TILE_LOG2-1:0] == '0) && (y_q[TILE_LOG2-1:0] == '0);
    eligible = pend_q && (aligned || (pdir_q == (dir_q ^ 2'b01)) || !moving_q);

    if (key[2]) begin
      pdir_d = key[1:0];
      if (!(key[1:0] == dir_q && moving_q)) pend_d = 1'b1;
    end

    if (frame_tick && state_q != IDLE) over_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          if (eligible) begin
            state_d = TURN_Q;
            qdir_d  = pdir_q;
            req_d   = 1'b1;
            wx_d    = step_x(x_q, pdir_q);
            wy_d    = step_y(y_q, pdir_q);
          end else if (moving_q) begin
            state_d = AHEAD_Q;
            qdir_d  = dir_q;
            req_d   = 1'b1;
            wx_d    = step_x(x_q, dir_q);
            wy_d    = step_y(y_q, dir_q);
          end
        end
      end
      TURN_Q: begin
        if (wall_ack) begin
          if (!wall_hit) begin
            state_d  = MOVE;
            dir_d    = qdir_q;
            moving_d = 1'b1;
            pend_d   = 1'b0;
            req_d    = 1'b0;
          end else if (moving_q) begin
            state_d = AHEAD_Q;
            qdir_d  = dir_q;
            wx_d    = step_x(x_q, dir_q);
            wy_d    = step_y(y_q, dir_q);
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end
      end
      AHEAD_Q: begin
        if (wall_ack) begin
          req_d = 1'b0;
          if (wall_hit) begin
            state_d  = IDLE;
            moving_d = 1'b0;
          end else begin
            state_d = MOVE;
          end
        end
      end
      MOVE: begin
        state_d = IDLE;
        case (dir_q)
          DIR_R:   cx = clamp_axis(xs + STEP_S, XLO, XHI);
          DIR_L:   cx = clamp_axis(xs - STEP_S, XLO, XHI);
          DIR_D:   cy = clamp_axis(ys + STEP_S, YLO, YHI);
          default: cy = clamp_axis(ys - STEP_S, YLO, YHI);
        endcase
        if (dir_q == DIR_R || dir_q == DIR_L) x_d = cx[W-1:0];
        else                                  y_d = cy[W-1:0];
        if (cx[W] || cy[W]) moving_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wall_req = req_q;
  assign wall_x   = wx_q;
  assign wall_y   = wy_q;
  assign BallX    = x_q;
  assign BallY    = y_q;
  assign BallS    = W'(SIZE);
  assign dir      = dir_q;
  assign moving   = moving_q;
  assign overrun  = over_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: directed scenarios plus randomized keys, ticks and
// wall responses, every cycle compared against a behavioural reference model.
`timescale 1ns/1ps
module tb_sprite_mover;

  localparam int W    = 10;
  localparam int SIZE = 4;
  localparam int XMIN = 26, XMAX = 598, YMIN = 26, YMAX = 454;
  localparam int PH_IDLE = 0, PH_TURN = 1, PH_AHEAD = 2, PH_MOVE = 3;

  logic         Clk, Reset, frame_tick, wall_ack, wall_hit;
  logic [7:0]   keycode;
  logic         wall_req, moving, overrun;
  logic [W-1:0] wall_x, wall_y, BallX, BallY, BallS;
  logic [1:0]   dir;

  sprite_mover #(.W(W)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
    .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
    .wall_ack(wall_ack), .wall_hit(wall_hit),
    .BallX(BallX), .BallY(BallY), .BallS(BallS),
    .dir(dir), .moving(moving), .overrun(overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  int m_x, m_y, m_dir, m_mov, m_pdir, m_pend, m_over, m_ph, m_qdir, m_req, m_wx, m_wy;

  // Responder knobs
  int ack_delay = 0;
  int wait_cnt  = 0;
  bit hit_val   = 0;
  bit spur_en   = 0;

  function automatic int key_dir(input logic [7:0] k);
    case (k)
      8'h07:   return 0;
      8'h04:   return 1;
      8'h16:   return 2;
      8'h1A:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int dx(input int d);
    return (d == 0) ? 1 : (d == 1) ? -1 : 0;
  endfunction

  function automatic int dy(input int d);
    return (d == 2) ? 1 : (d == 3) ? -1 : 0;
  endfunction

  function automatic int opposite(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    m_x = 320; m_y = 240; m_dir = 0; m_mov = 0; m_pdir = 0; m_pend = 0;
    m_over = 0; m_ph = PH_IDLE; m_qdir = 0; m_req = 0; m_wx = 320; m_wy = 240;
  endtask

  task automatic issue(input int d);
    m_req = 1;
    m_wx  = m_x + dx(d);
    m_wy  = m_y + dy(d);
  endtask

  // One clock of the reference behaviour, from the inputs seen at the edge.
  task automatic model_step(input bit tk, input logic [7:0] kc, input bit ack, input bit hit);
    int kd, np, npd, nx, ny;
    bit al;
    kd  = key_dir(kc);
    np  = m_pend;
    npd = m_pdir;
    if (kd >= 0) begin
      npd = kd;
      if (!(kd == m_dir && m_mov != 0)) np = 1;
    end
    if (tk && m_ph != PH_IDLE) m_over = 1;
    case (m_ph)
      PH_IDLE: if (tk) begin
        al = (m_x % 8 == 0) && (m_y % 8 == 0);
        if (m_pend != 0 && (al || m_pdir == opposite(m_dir) || m_mov == 0)) begin
          m_ph = PH_TURN; m_qdir = m_pdir; issue(m_qdir);
        end else if (m_mov != 0) begin
          m_ph = PH_AHEAD; m_qdir = m_dir; issue(m_qdir);
        end
      end
      PH_TURN: if (ack) begin
        if (!hit) begin
          m_dir = m_qdir; m_mov = 1; np = 0; m_ph = PH_MOVE; m_req = 0;
        end else if (m_mov != 0) begin
          m_ph = PH_AHEAD; m_qdir = m_dir; issue(m_qdir);
        end else begin
          m_ph = PH_IDLE; m_req = 0;
        end
      end
      PH_AHEAD: if (ack) begin
        m_req = 0;
        if (hit) begin m_mov = 0; m_ph = PH_IDLE; end
        else m_ph = PH_MOVE;
      end
      default: begin
        nx = m_x + dx(m_dir);
        ny = m_y + dy(m_dir);
        if (m_dir < 2) begin
          if (nx - SIZE <= XMIN)      begin nx = XMIN + SIZE; m_mov = 0; end
          else if (nx + SIZE >= XMAX) begin nx = XMAX - SIZE; m_mov = 0; end
        end else begin
          if (ny - SIZE <= YMIN)      begin ny = YMIN + SIZE; m_mov = 0; end
          else if (ny + SIZE >= YMAX) begin ny = YMAX - SIZE; m_mov = 0; end
        end
        m_x = nx; m_y = ny; m_ph = PH_IDLE;
      end
    endcase
    m_pend = np;
    m_pdir = npd;
  endtask

  task automatic compare_all();
    check_eq("BallX", BallX, m_x);
    check_eq("BallY", BallY, m_y);
    check_eq("dir", dir, m_dir);
    check_eq("moving", moving, m_mov);
    check_eq("overrun", overrun, m_over);
    check_eq("wall_req", wall_req, m_req);
    if (m_req != 0) begin
      check_eq("wall_x", wall_x, m_wx);
      check_eq("wall_y", wall_y, m_wy);
    end
  endtask

  // One clock: drive inputs (wall responder included), step model, compare.
  task automatic cyc(input bit tk, input logic [7:0] kc);
    frame_tick = tk;
    keycode    = kc;
    if (wall_req) begin
      if (wait_cnt >= ack_delay) begin wall_ack = 1'b1; wait_cnt = 0; end
      else begin wall_ack = 1'b0; wait_cnt++; end
    end else begin
      wall_ack = spur_en && ($urandom_range(0, 7) == 0);
      wait_cnt = 0;
    end
    wall_hit = hit_val;
    @(posedge Clk);
    model_step(tk, kc, wall_ack, wall_hit);
    #1 compare_all();
    @(negedge Clk);
  endtask

  task automatic frame();
    cyc(1'b1, 8'h00);
    for (int i = 0; i < 60 && (m_ph != PH_IDLE || m_req != 0); i++) cyc(1'b0, 8'h00);
    check_eq("frame_req_low", wall_req, 0);
  endtask

  // Entered at a falling edge; reset takes effect without waiting for a clock.
  task automatic do_reset();
    Reset = 1'b0; frame_tick = 1'b0; keycode = 8'h00; wall_ack = 1'b0; wall_hit = 1'b0;
    wait_cnt = 0;
    #1;
    model_reset();
    compare_all();
    check_eq("rst_BallS", BallS, SIZE);
    check_eq("rst_wall_x", wall_x, 320);
    check_eq("rst_wall_y", wall_y, 240);
    @(posedge Clk);
    #1 compare_all();
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] k;
    int r;
    Reset = 1'b0; frame_tick = 1'b0; keycode = 8'h00; wall_ack = 1'b0; wall_hit = 1'b0;
    @(negedge Clk);
    do_reset();

    // Grant first move right, zero-wait ack, update on the 3rd edge.
    cyc(1'b0, 8'h07);
    cyc(1'b1, 8'h00);
    check_eq("r24_wall_req", wall_req, 1);
    check_eq("r24_wall_x", wall_x, 321);
    check_eq("r24_wall_y", wall_y, 240);
    cyc(1'b0, 8'h00);
    check_eq("r24_x_hold", BallX, 320);
    cyc(1'b0, 8'h00);
    check_eq("r24_BallX", BallX, 321);
    check_eq("r24_dir", dir, 0);
    check_eq("r24_moving", moving, 1);
    cyc(1'b0, 8'h00);

    // Pending down turn waits for tile alignment at X=328.
    cyc(1'b0, 8'h16);
    for (int g = 0; g < 20 && m_x != 328; g++) begin
      frame();
      check_eq("r25_dir_before", dir, 0);
    end
    check_eq("r25_at328", BallX, 328);
    cyc(1'b1, 8'h00);
    check_eq("r25_wall_x", wall_x, 328);
    check_eq("r25_wall_y", wall_y, 241);
    repeat (3) cyc(1'b0, 8'h00);
    check_eq("r25_dir", dir, 2);
    check_eq("r25_BallY", BallY, 241);
    check_eq("r25_BallX", BallX, 328);

    // Reverse is granted immediately even when unaligned.
    do_reset();
    cyc(1'b0, 8'h07);
    repeat (3) frame();
    check_eq("r26_at323", BallX, 323);
    cyc(1'b0, 8'h04);
    frame();
    check_eq("r26_BallX", BallX, 322);
    check_eq("r26_dir", dir, 1);

    // Wall ahead stops the sprite; a later tick without a key does nothing.
    do_reset();
    cyc(1'b0, 8'h07);
    frame();
    hit_val = 1'b1;
    frame();
    hit_val = 1'b0;
    check_eq("r27_moving", moving, 0);
    check_eq("r27_BallX", BallX, 321);
    cyc(1'b1, 8'h00);
    check_eq("r27_no_req", wall_req, 0);
    repeat (3) begin
      cyc(1'b0, 8'h00);
      check_eq("r27_no_req_later", wall_req, 0);
    end

    // Right-hand bound clamps at 594 and stops.
    do_reset();
    cyc(1'b0, 8'h07);
    for (int g = 0; g < 400 && m_x < 593; g++) frame();
    check_eq("r28_at593", BallX, 593);
    frame();
    check_eq("r28_BallX", BallX, 594);
    check_eq("r28_moving", moving, 0);
    cyc(1'b1, 8'h00);
    check_eq("r28_no_req", wall_req, 0);
    repeat (3) cyc(1'b0, 8'h00);
    check_eq("r28_BallX_after", BallX, 594);

    // Slow ack: tick during the wait sets overrun and is dropped; reset mid-wait.
    do_reset();
    cyc(1'b0, 8'h07);
    frame();
    ack_delay = 5;
    cyc(1'b1, 8'h00);
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h00);
    check_eq("r29_overrun", overrun, 1);
    check_eq("r29_still_req", wall_req, 1);
    for (int g = 0; g < 20 && (m_ph != PH_IDLE || m_req != 0); g++) cyc(1'b0, 8'h00);
    check_eq("r29_one_move", BallX, 322);
    check_eq("r29_overrun_sticky", overrun, 1);
    cyc(1'b1, 8'h00);
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    check_eq("r29_req_before_rst", wall_req, 1);
    do_reset();
    check_eq("r29_rst_req", wall_req, 0);
    check_eq("r29_rst_BallX", BallX, 320);
    check_eq("r29_rst_BallY", BallY, 240);
    ack_delay = 0;

    // Randomized traffic against the model.
    do_reset();
    spur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 16 == 0) ack_delay = $urandom_range(0, 3);
      hit_val = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 11);
      case (r)
        0: k = 8'h04;
        1: k = 8'h07;
        2: k = 8'h16;
        3: k = 8'h1A;
        4: k = 8'h55;
        default: k = 8'h00;
      endcase
      cyc($urandom_range(0, 4) == 0, k);
    end
    spur_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_mover.md
SPRITE_MOVER -- requirements
Module: sprite_mover

Interface
REQ-001 SHALL have parameter W, default 10, giving the coordinate width.
REQ-002 SHALL have parameters X_CENTER=320 and Y_CENTER=240, giving the reset position.
REQ-003 SHALL have parameters X_MIN=26, X_MAX=598, Y_MIN=26 and Y_MAX=454, giving the playfield bounds.
REQ-004 SHALL have parameters SIZE=4 (sprite half-size), STEP=1 (pixels per move) and TILE_LOG2=3 (turn-alignment grid, 2^TILE_LOG2 px).
REQ-005 SHALL have ports as follows:
- Clk  in  1  system clock, the only clock.
- Reset  in  1  asynchronous, active-low; 0 = reset.
- frame_tick  in  1  single-cycle move-enable pulse, once per frame.
- keycode  in  8  key code: 0x04=A/left, 0x07=D/right, 0x16=S/down, 0x1A=W/up; all other codes ignored.
- wall_req  out  1  wall-map query valid.
- wall_x, wall_y  out  W  candidate position being queried.
- wall_ack  in  1  query response valid, single cycle.
- wall_hit  in  1  candidate blocked; sampled only with wall_ack.
- BallX, BallY, BallS  out  W  sprite position and size (BallS = SIZE).
- dir  out  2  current direction: 0=right, 1=left, 2=down, 3=up.
- moving  out  1  sprite in motion.
- overrun  out  1  sticky: frame_tick seen while not IDLE.

Function
REQ-006 SHALL implement FSM states IDLE, TURN_Q, AHEAD_Q and MOVE.
REQ-007 SHALL sample keycode every Clk; a valid key SHALL load the pending direction (pdir) and set pend_valid. A valid key equal to dir while moving SHALL NOT set pend_valid. Ignored codes SHALL leave pdir and pend_valid unchanged.
REQ-008 Aligned SHALL mean the low TILE_LOG2 bits of both BallX and BallY are zero.
REQ-009 Turn-eligible SHALL mean pend_valid and (aligned, or pdir is the reverse of dir, or moving=0).
REQ-010 In IDLE on frame_tick:
- turn-eligible -> TURN_Q, latch qdir=pdir;
- else moving=1 -> AHEAD_Q, qdir=dir;
- else stay in IDLE.
REQ-011 On entering TURN_Q or AHEAD_Q, the module SHALL drive wall_x/wall_y = position + STEP in qdir and assert wall_req. wall_req and the wall_x/wall_y values SHALL stay stable until the wall_ack cycle, and wall_req SHALL drop on the next edge.
REQ-012 TURN_Q on wall_ack:
- hit=0 -> dir=qdir, moving=1, pend_valid=0, go to MOVE;
- hit=1 and moving=1 -> AHEAD_Q with qdir=dir, pend_valid retained;
- hit=1 and moving=0 -> IDLE, pend_valid retained.
REQ-013 AHEAD_Q on wall_ack: hit=1 -> moving=0, go to IDLE; hit=0 -> MOVE.
REQ-014 MOVE SHALL add or subtract STEP on one axis per dir, then return to IDLE; the position register updates on the edge leaving MOVE.
REQ-015 Bounds: if the new position ±SIZE would cross X_MIN/X_MAX or Y_MIN/Y_MAX, the position SHALL clamp to exactly MIN+SIZE or MAX-SIZE and moving SHALL clear.
REQ-016 All position arithmetic SHALL be W-bit unsigned with no wrap; the clamp is evaluated before truncation.
REQ-017 Minimum latency from frame_tick to position update SHALL be 3 Clk with zero-wait ack (IDLE->Q, Q->MOVE, MOVE->IDLE).
REQ-018 A frame_tick outside IDLE SHALL be dropped and SHALL set overrun; overrun SHALL clear only on reset.
REQ-019 A keycode change during a query SHALL update pdir only; the in-flight query SHALL keep qdir.
REQ-020 A wall_ack in IDLE or MOVE SHALL be ignored.

Reset
REQ-021 While Reset=0, the module SHALL asynchronously force: FSM=IDLE, BallX=X_CENTER, BallY=Y_CENTER, dir=0, moving=0, pend_valid=0, pdir=0, wall_req=0, wall_x=X_CENTER, wall_y=Y_CENTER, overrun=0.
REQ-022 Reset asserted mid-query SHALL drop wall_req in the same cycle, with no position change.
REQ-023 BallS SHALL equal SIZE at all times, including during reset.

Verification
REQ-024 Bench SHALL check: release reset, keycode=0x07, frame_tick, immediate ack hit=0 -> wall_x=321 during the query, BallX=321, dir=0, moving=1, update 3 Clk after the tick.
REQ-025 Bench SHALL check: moving right at (321,240), keycode=0x16 -> no turn until BallX=328; at (328,240) the tick queries (328,241), and hit=0 gives dir=2, BallY=241.
REQ-026 Bench SHALL check: moving right, keycode=0x04 at unaligned X=323 -> reverse granted on the next tick, BallX=322, dir=1.
REQ-027 Bench SHALL check: moving right, ack hit=1 in AHEAD_Q -> moving=0, BallX unchanged; a later tick with no pending key stays in IDLE with no wall_req.
REQ-028 Bench SHALL check: BallX=593, moving right, hit=0 -> BallX=594, moving=0; the next tick issues no query.
REQ-029 Bench SHALL check: hold wall_ack low 5 Clk, pulse frame_tick mid-wait -> overrun=1, one move only; Reset=0 mid-wait -> wall_req=0 immediately, BallX=320, BallY=240.
